// File: rtl/song_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : song_sequencer
//  Purpose  : Note sequencer for the buzzer/LED/display datapath. Free mode
//             passes the user note straight through; auto mode plays a
//             16-entry note memory with per-note length, inter-note gap,
//             pause/resume and a terminal DONE state.
//  Revision : 1.0 - initial release
// ============================================================================
module song_sequencer #(
  parameter int unsigned BEAT_CYCLES = 25_000_000,
  parameter int unsigned GAP_CYCLES  = 5_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_sel,
  input  logic       start,
  input  logic       pause,
  input  logic [3:0] user_input,
  input  logic       higher_8,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic [3:0] key,
  output logic       key_on,
  output logic       higher_8_out,
  output logic [3:0] step_index,
  output logic       playing,
  output logic       done
);

  // Counter must hold the longest note (7 beats) or the gap, whichever is larger.
  localparam int unsigned C_NOTE_MAX = 7 * BEAT_CYCLES;
  localparam int unsigned C_CNT_MAX  = (C_NOTE_MAX > GAP_CYCLES) ? C_NOTE_MAX : GAP_CYCLES;
  localparam int          CNT_W      = $clog2(C_CNT_MAX + 1);

  localparam logic [CNT_W-1:0] C_BEAT = CNT_W'(BEAT_CYCLES);
  localparam logic [CNT_W-1:0] C_GAP  = CNT_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_NOTE   = 3'd1;
  localparam logic [2:0] S_GAP    = 3'd2;
  localparam logic [2:0] S_PAUSED = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;       // cycles still to play in the current phase
  logic             ret_gap_q, ret_gap_d; // phase to resume after PAUSED (1 = GAP)
  logic [3:0]       step_q, step_d;
  logic [3:0]       key_q, key_d;
  logic             hi_q, hi_d;
  logic             key_on_q, key_on_d;
  logic             playing_q, playing_d;
  logic             done_q, done_d;
  logic [7:0]       mem_q [16];
  logic [7:0]       mem_d [16];

  logic             finish;       // current phase has run its full length
  logic             finish_gap;   // the phase that finished was a GAP
  logic             do_fetch;
  logic [3:0]       fetch_addr;
  logic [7:0]       fetch_data;

  // State, counters, memory and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rem_q     <= '0;
      ret_gap_q <= 1'b0;
      step_q    <= 4'd0;
      key_q     <= 4'd0;
      hi_q      <= 1'b0;
      key_on_q  <= 1'b0;
      playing_q <= 1'b0;
      done_q    <= 1'b0;
      for (int i = 0; i < 16; i++) mem_q[i] <= 8'h00;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      ret_gap_q <= ret_gap_d;
      step_q    <= step_d;
      key_q     <= key_d;
      hi_q      <= hi_d;
      key_on_q  <= key_on_d;
      playing_q <= playing_d;
      done_q    <= done_d;
      for (int i = 0; i < 16; i++) mem_q[i] <= mem_d[i];
    end
  end

  // Next state: phase sequencing, pause bookkeeping and note fetch.
  // The fetch reads mem_q, so a same-cycle write to that address is not seen.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    ret_gap_d  = ret_gap_q;
    step_d     = step_q;
    key_d      = key_q;
    hi_d       = hi_q;
    mem_d      = mem_q;
    finish     = 1'b0;
    finish_gap = 1'b0;
    do_fetch   = 1'b0;
    fetch_addr = 4'd0;
    fetch_data = 8'h00;

    if (wr_en) mem_d[wr_addr] = wr_data;

    if (!mode_sel) begin
      state_d   = S_IDLE;
      rem_d     = '0;
      ret_gap_d = 1'b0;
      step_d    = 4'd0;
      key_d     = user_input;
      hi_d      = higher_8;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) do_fetch = 1'b1;
        end
        S_NOTE, S_GAP: begin
          // The pause cycle still counts as played time, so the count
          // advances on the pausing edge as well; it may reach zero.
          if (pause) begin
            state_d   = S_PAUSED;
            ret_gap_d = (state_q == S_GAP);
            rem_d     = rem_q - C_ONE;
          end else if (rem_q == C_ONE) begin
            finish     = 1'b1;
            finish_gap = (state_q == S_GAP);
          end else begin
            rem_d = rem_q - C_ONE;
          end
        end
        S_PAUSED: begin
          if (pause) begin
            if (rem_q == '0) begin
              finish     = 1'b1;
              finish_gap = ret_gap_q;
            end else begin
              state_d = ret_gap_q ? S_GAP : S_NOTE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (finish) begin
      if (!finish_gap && (GAP_CYCLES != 0)) begin
        state_d = S_GAP;
        rem_d   = C_GAP;
      end else if (step_q == 4'd15) begin
        state_d = S_DONE;
        rem_d   = '0;
      end else begin
        do_fetch   = 1'b1;
        fetch_addr = step_q + 4'd1;
      end
    end

    if (do_fetch) begin
      fetch_data = mem_q[fetch_addr];
      step_d     = fetch_addr;
      if (fetch_data[7:5] == 3'd0) begin
        state_d = S_DONE;
        rem_d   = '0;
      end else begin
        state_d = S_NOTE;
        rem_d   = CNT_W'(fetch_data[7:5]) * C_BEAT;
        key_d   = fetch_data[3:0];
        hi_d    = fetch_data[4];
      end
    end
  end

  // Output decode from the next state so every output leaves a flop.
  always_comb begin
    key_on_d  = !mode_sel || ((state_d == S_NOTE) && (key_d != 4'd0));
    playing_d = (state_d == S_NOTE) || (state_d == S_GAP) || (state_d == S_PAUSED);
    done_d    = (state_d == S_DONE);
  end

  assign key          = key_q;
  assign key_on       = key_on_q;
  assign higher_8_out = hi_q;
  assign step_index   = step_q;
  assign playing      = playing_q;
  assign done         = done_q;

endmodule
`default_nettype wire
